sa_input_feeder: RTL
====================

// Module: sa_input_feeder
// PURPOSE
//   Upstream stage of the systolic matmul: on i_start, reads K input-activation columns from the input
//   memory (sync read, 1-cycle latency) and drives them into the array's west edge with the diagonal skew.
//   Row r is delayed r cycles relative to row 0. Non-valid lanes are driven to zero (bubbles).
//   The matmul control block starts it and waits for o_done before draining the array.
// PARAMETERS
//   MUL_DATAWIDTH  8   width of one activation element
//   NUM_ROWS       4   array rows = lanes per memory word
//   ADDR_WIDTH     10  input-memory address width
//   KLEN_WIDTH     10  width of reduction-length field
// PORTS
//   clk          in   1                        clock; single clock domain
//   rst_n        in   1                        reset, asynchronous, active-low
//   i_start      in   1                        start pulse; sampled only in IDLE
//   i_base_addr  in   ADDR_WIDTH               address of column 0; captured with i_start
//   i_k_len      in   KLEN_WIDTH               number of columns K; captured with i_start
//   o_mem_ren    out  1                        input-memory read enable
//   o_mem_addr   out  ADDR_WIDTH               input-memory read address
//   i_mem_rdata  in   NUM_ROWS*MUL_DATAWIDTH   read data, valid 1 cycle after ren; lane r = bits [r*MUL_DATAWIDTH +: MUL_DATAWIDTH]
//   o_row_data   out  NUM_ROWS*MUL_DATAWIDTH   skewed activations to array rows; same lane packing as i_mem_rdata
//   o_row_valid  out  NUM_ROWS                 per-row element-valid
//   o_busy       out  1                        high in READ/DRAIN/DONE
//   o_done       out  1                        1-cycle completion pulse
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; counters and skew registers cleared. Reset mid-operation aborts at once.
//     No done pulse; next i_start begins cleanly.
//   FSM: IDLE -> READ (i_start, K>0); IDLE -> DONE (i_start, K==0);
//     READ -> DRAIN (after K-th read issued); DRAIN -> DONE (after NUM_ROWS+1 cycles);
//     DONE -> IDLE (unconditional, 1 cycle).
//   T0 = cycle i_start is sampled high in IDLE.
//     i_start in any other state, including DONE, is ignored.
//   READ: during cycle T0+1+k (k=0..K-1), o_mem_ren=1 and o_mem_addr=base+k.
//     Address wraps modulo 2^ADDR_WIDTH. o_mem_ren=0 in all other states.
//   Data path: rdata is registered into stage 0. Lane r passes through r more registers (sa_skew_delay).
//     Element k of row r appears on o_row_data/o_row_valid during cycle T0+3+k+r.
//   A valid bit travels with each element through every stage.
//     o_row_data lane r = 0 whenever o_row_valid[r]=0.
//   o_done high for the single cycle T0+K+NUM_ROWS+2, the cycle after the last valid element of row NUM_ROWS-1.
//     For K==0, o_done is high in cycle T0+1 and no read is issued.
//   o_busy = (state != IDLE).
//     Changes to i_base_addr/i_k_len after T0 have no effect.
//   No backpressure: the array always consumes; valid output is never stalled.
// STRUCTURE
//   sa_pkg: feeder_state_t enum {IDLE, READ, DRAIN, DONE}; default parameter constants;
//     lane-slice helper function.
//   Sub-module sa_skew_delay #(WIDTH, DEPTH) carries {valid, data} with async reset.
//     One instance per row (DEPTH=r) via generate; DEPTH=0 degenerates to a wire.
//   Top level holds the FSM, the k/drain counters, the address register and the stage-0 register.
// TESTING (NUM_ROWS=4, MUL_DATAWIDTH=8; memory model lane r at addr base+k = 8'h{k,r})
//   1 Basic: base=0x10, K=3 -> ren in T0+1..T0+3 at addrs 0x10..0x12.
//     Row2 shows 0x02, 0x12, 0x22 at T0+5..T0+7, 0 otherwise. o_done at T0+9 only.
//   2 K=1, base=0x3FF -> one read at 0x3FF; row3 valid only at T0+6 with 0x03; o_done at T0+7.
//   3 Wrap: base=0x3FE, K=4 -> addrs 0x3FE, 0x3FF, 0x000, 0x001.
//   4 K=0 -> no ren; o_done at T0+1; o_row_valid stays 0.
//   5 i_start re-pulsed during READ and during DONE -> ignored. Exactly one done; no extra reads.
//   6 rst_n low at T0+4 of a K=8 job -> all outputs 0 immediately; no done.
//     Restart with K=2 behaves as a fresh job.
//   Checker: scoreboard per row on (cycle, value).
//     Assertions: o_row_data lane r = 0 when its valid is low; o_done one cycle wide; ren only in READ.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array input feeder and its skew line.
package sa_pkg;

  localparam int unsigned MUL_DATAWIDTH_DEF = 8;
  localparam int unsigned NUM_ROWS_DEF      = 4;
  localparam int unsigned ADDR_WIDTH_DEF    = 10;
  localparam int unsigned KLEN_WIDTH_DEF    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // Extract one activation lane from a packed row word (default geometry).
  function automatic logic [MUL_DATAWIDTH_DEF-1:0] lane_slice(
    input logic [NUM_ROWS_DEF*MUL_DATAWIDTH_DEF-1:0] word,
    input int unsigned                               lane
  );
    return word[lane*MUL_DATAWIDTH_DEF +: MUL_DATAWIDTH_DEF];
  endfunction

endpackage

// File: rtl/sa_skew_delay.sv
// Fixed-depth delay line carrying {valid, data}; DEPTH=0 collapses to a plain wire.
module sa_skew_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_valid        = d_valid;
    assign q_data         = d_data;
  end else begin : g_pipe
    logic [WIDTH:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= {d_valid, d_data};
        for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign {q_valid, q_data} = pipe[DEPTH-1];
  end

endmodule

// File: rtl/sa_input_feeder.sv
// Reads K activation columns from input memory and feeds them diagonally skewed
// into the west edge of the systolic array, signalling completion with o_done.
module sa_input_feeder
  import sa_pkg::*;
#(
  parameter int unsigned MUL_DATAWIDTH = MUL_DATAWIDTH_DEF,
  parameter int unsigned NUM_ROWS      = NUM_ROWS_DEF,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned KLEN_WIDTH    = KLEN_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [ADDR_WIDTH-1:0]             i_base_addr,
  input  logic [KLEN_WIDTH-1:0]             i_k_len,
  output logic                              o_mem_ren,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  input  logic [NUM_ROWS*MUL_DATAWIDTH-1:0] i_mem_rdata,
  output logic [NUM_ROWS*MUL_DATAWIDTH-1:0] o_row_data,
  output logic [NUM_ROWS-1:0]               o_row_valid,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int unsigned DATA_W  = NUM_ROWS * MUL_DATAWIDTH;
  localparam int unsigned DRAIN_W = $clog2(NUM_ROWS + 1);
  // Drain lasts NUM_ROWS+1 cycles: memory latency, stage 0 and the deepest skew line.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_ROWS);

  feeder_state_t         state, state_nxt;
  logic [KLEN_WIDTH-1:0] k_len, k_len_nxt;
  logic [KLEN_WIDTH-1:0] k_cnt, k_cnt_nxt;
  logic [DRAIN_W-1:0]    drain_cnt, drain_nxt;
  logic                  ren_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  done_nxt;

  logic                  rd_pending;
  logic                  stage0_valid;
  logic [DATA_W-1:0]     stage0_data;

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k_len      <= '0;
      k_cnt      <= '0;
      drain_cnt  <= '0;
      o_mem_ren  <= 1'b0;
      o_mem_addr <= '0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      k_len      <= k_len_nxt;
      k_cnt      <= k_cnt_nxt;
      drain_cnt  <= drain_nxt;
      o_mem_ren  <= ren_nxt;
      o_mem_addr <= addr_nxt;
      o_done     <= done_nxt;
      o_busy     <= (state_nxt != IDLE);
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    k_len_nxt = k_len;
    k_cnt_nxt = k_cnt;
    drain_nxt = drain_cnt;
    ren_nxt   = 1'b0;
    addr_nxt  = o_mem_addr;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          k_len_nxt = i_k_len;
          k_cnt_nxt = '0;
          if (i_k_len == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = READ;
            ren_nxt   = 1'b1;
            addr_nxt  = i_base_addr;
          end
        end
      end
      READ: begin
        if (k_cnt == k_len - KLEN_WIDTH'(1)) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else begin
          ren_nxt   = 1'b1;
          addr_nxt  = o_mem_addr + ADDR_WIDTH'(1);
          k_cnt_nxt = k_cnt + KLEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          drain_nxt = drain_cnt + DRAIN_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read-return tracking and stage-0 capture; bubbles are forced to zero here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending   <= 1'b0;
      stage0_valid <= 1'b0;
      stage0_data  <= '0;
    end else begin
      rd_pending   <= o_mem_ren;
      stage0_valid <= rd_pending;
      stage0_data  <= rd_pending ? i_mem_rdata : '0;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    sa_skew_delay #(
      .WIDTH (MUL_DATAWIDTH),
      .DEPTH (r)
    ) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_valid (stage0_valid),
      .d_data  (stage0_data[r*MUL_DATAWIDTH +: MUL_DATAWIDTH]),
      .q_valid (o_row_valid[r]),
      .q_data  (o_row_data[r*MUL_DATAWIDTH +: MUL_DATAWIDTH])
    );
  end

endmodule
